// File: rtl/rs_dec_sched.sv
// rs_dec_sched: frame-level scheduler for the RS decoder datapath.
// It accepts one codeword at a time on the symbol bus, strobes the syndrome
// unit with a lane mask, and then runs BM and Chien/Forney through
// start/done handshakes. Waits for a done pulse are bounded by a timeout.
// Optional build macro RS_ZERO_SYND_SKIP_EN: when all syndromes are zero,
// BM and Chien are skipped and the frame completes right after SYND.
module rs_dec_sched #(
   parameter int N_LEN             = 255,
   parameter int BUS_WIDTH_IN_SYMB = 4,
   parameter int BEATS             = (N_LEN + BUS_WIDTH_IN_SYMB - 1) / BUS_WIDTH_IN_SYMB,
   parameter int TMO_CYCLES        = 1024
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         s_valid,
   input  logic                         s_last,
   output logic                         s_ready,
   output logic                         synd_en,
   output logic                         synd_first,
   output logic [BUS_WIDTH_IN_SYMB-1:0] synd_mask,
   input  logic                         synd_zero,
   output logic                         bm_start,
   input  logic                         bm_done,
   output logic                         chien_start,
   input  logic                         chien_done,
   output logic                         frame_done,
   output logic                         frame_err,
   output logic                         busy
);

   localparam int CW  = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int TW  = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;
   localparam int REM = N_LEN % BUS_WIDTH_IN_SYMB;

   localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
   localparam logic [TW-1:0] TMO_LAST  = TW'(TMO_CYCLES - 1);
   localparam logic [BUS_WIDTH_IN_SYMB-1:0] FULL_MASK = '1;
   // Only the low REM lanes of the final beat carry codeword symbols.
   localparam logic [BUS_WIDTH_IN_SYMB-1:0] LAST_MASK =
      (REM == 0) ? FULL_MASK : BUS_WIDTH_IN_SYMB'((1 << REM) - 1);

   typedef enum logic [2:0] {
      IDLE, RECV, SYND, BM_START, BM_WAIT, CH_START, CH_WAIT, DONE
   } state_t;

   state_t        state;
   logic [CW-1:0] beat_cnt;
   logic [TW-1:0] tmo_cnt;

   // Input acceptance and syndrome-unit strobes, same cycle as the beat.
   always_comb begin
      s_ready    = (state == IDLE) || (state == RECV);
      synd_en    = s_valid && s_ready;
      synd_first = synd_en && (beat_cnt == '0);
      synd_mask  = (beat_cnt == LAST_BEAT) ? LAST_MASK : FULL_MASK;
      busy       = (state != IDLE);
   end

`ifndef RS_ZERO_SYND_SKIP_EN
   // Without the skip feature the syndrome-zero flag has no consumer.
   logic unused_synd_zero;
   assign unused_synd_zero = synd_zero;
`endif

   // Frame sequencer with registered one-cycle pulse outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         beat_cnt    <= '0;
         tmo_cnt     <= '0;
         bm_start    <= 1'b0;
         chien_start <= 1'b0;
         frame_done  <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         bm_start    <= 1'b0;
         chien_start <= 1'b0;
         frame_done  <= 1'b0;
         frame_err   <= 1'b0;
         case (state)
            IDLE, RECV: begin
               // s_ready is high here, so a valid beat is always accepted.
               if (s_valid) begin
                  if (beat_cnt == LAST_BEAT) begin
                     beat_cnt <= '0;
                     if (s_last) begin
                        state <= SYND;
                     end else begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                     end
                  end else if (s_last) begin
                     beat_cnt  <= '0;
                     frame_err <= 1'b1;
                     state     <= IDLE;
                  end else begin
                     beat_cnt <= beat_cnt + 1'b1;
                     state    <= RECV;
                  end
               end
            end
            SYND: begin
`ifdef RS_ZERO_SYND_SKIP_EN
               if (synd_zero) begin
                  frame_done <= 1'b1;
                  state      <= DONE;
               end else begin
                  bm_start <= 1'b1;
                  state    <= BM_START;
               end
`else
               bm_start <= 1'b1;
               state    <= BM_START;
`endif
            end
            BM_START: begin
               tmo_cnt <= '0;
               state   <= BM_WAIT;
            end
            BM_WAIT: begin
               // A done pulse on the timeout cycle still wins.
               if (bm_done) begin
                  chien_start <= 1'b1;
                  state       <= CH_START;
               end else if (tmo_cnt == TMO_LAST) begin
                  frame_err <= 1'b1;
                  state     <= IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            CH_START: begin
               tmo_cnt <= '0;
               state   <= CH_WAIT;
            end
            CH_WAIT: begin
               if (chien_done) begin
                  frame_done <= 1'b1;
                  state      <= DONE;
               end else if (tmo_cnt == TMO_LAST) begin
                  frame_err <= 1'b1;
                  state     <= IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rs_dec_sched.sv
// Directed bench for rs_dec_sched at default parameters.
module tb_rs_dec_sched;

   logic       clk = 1'b0;
   logic       rst;
   logic       s_valid, s_last, s_ready;
   logic       synd_en, synd_first;
   logic [3:0] synd_mask;
   logic       synd_zero;
   logic       bm_start, bm_done, chien_start, chien_done;
   logic       frame_done, frame_err, busy;

   int n_vec = 0;
   int n_err = 0;

   // Pulse/strobe event counters, sampled on the falling edge.
   int c_first = 0, c_en = 0, c_part = 0, c_bm = 0, c_ch = 0, c_fd = 0, c_fe = 0;

   rs_dec_sched dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
      .synd_en(synd_en), .synd_first(synd_first), .synd_mask(synd_mask),
      .synd_zero(synd_zero), .bm_start(bm_start), .bm_done(bm_done),
      .chien_start(chien_start), .chien_done(chien_done),
      .frame_done(frame_done), .frame_err(frame_err), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (synd_first) c_first++;
      if (synd_en) c_en++;
      if (synd_en && synd_mask != 4'b1111) c_part++;
      if (bm_start) c_bm++;
      if (chien_start) c_ch++;
      if (frame_done) c_fd++;
      if (frame_err) c_fe++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish, expected finish before 500000");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Send nb back-to-back beats, s_last on beat last_at (-1: never).
   task automatic send_frame(input int nb, input int last_at);
      for (int i = 0; i < nb; i++) begin
         s_valid = 1'b1;
         s_last  = (i == last_at);
         #1;
         if (i == 0)  chk("synd_first_beat0", synd_first, 1'b1);
         if (i == 62) chk("mask_beat62", synd_mask, 4'b1111);
         if (i == 63) chk("mask_beat63", synd_mask, 4'b0111);
         tick();
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   // Starting in the SYND cycle: bm_done 3 cycles after bm_start,
   // chien_done 10 cycles after chien_start.
   task automatic finish_nominal();
      chk("busy_synd", busy, 1'b1);
      tick();
      chk("bm_start_pulse", bm_start, 1'b1);
      tick();
      chk("bm_start_one_cycle", bm_start, 1'b0);
      tick();
      tick();
      bm_done = 1'b1;
      tick();
      bm_done = 1'b0;
      chk("chien_start_pulse", chien_start, 1'b1);
      repeat (10) tick();
      chien_done = 1'b1;
      tick();
      chien_done = 1'b0;
      chk("frame_done_pulse", frame_done, 1'b1);
      tick();
      chk("frame_done_one_cycle", frame_done, 1'b0);
      chk("busy_after_frame", busy, 1'b0);
   endtask

   initial begin
      int b_first, b_en, b_part, b_bm, b_ch, b_fd, b_fe;
      logic seen;
      rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; synd_zero = 1'b0;
      bm_done = 1'b0; chien_done = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tick();
      chk("reset_busy", busy, 1'b0);
      chk("reset_s_ready", s_ready, 1'b1);
      chk("reset_frame_err", frame_err, 1'b0);
      chk("reset_frame_done", frame_done, 1'b0);
      chk("reset_bm_start", bm_start, 1'b0);

      // Nominal frame.
      b_first = c_first; b_en = c_en; b_part = c_part; b_bm = c_bm;
      b_ch = c_ch; b_fd = c_fd; b_fe = c_fe;
      send_frame(64, 63);
      finish_nominal();
      chk("nom_first_count", c_first - b_first, 1);
      chk("nom_en_count", c_en - b_en, 64);
      chk("nom_partial_mask_count", c_part - b_part, 1);
      chk("nom_bm_count", c_bm - b_bm, 1);
      chk("nom_chien_count", c_ch - b_ch, 1);
      chk("nom_done_count", c_fd - b_fd, 1);
      chk("nom_err_count", c_fe - b_fe, 0);

      // Early s_last on beat 20, then a good frame.
      send_frame(21, 20);
      chk("early_frame_err", frame_err, 1'b1);
      chk("early_idle", busy, 1'b0);
      chk("early_s_ready", s_ready, 1'b1);
      tick();
      chk("early_err_one_cycle", frame_err, 1'b0);
      send_frame(64, 63);
      finish_nominal();

      // Missing s_last on beat 63, then a good frame.
      send_frame(64, -1);
      chk("nolast_frame_err", frame_err, 1'b1);
      chk("nolast_s_ready", s_ready, 1'b1);
      chk("nolast_idle", busy, 1'b0);
      tick();
      b_fd = c_fd;
      send_frame(64, 63);
      finish_nominal();
      chk("after_nolast_done", c_fd - b_fd, 1);

      // bm_done never returns: error TMO_CYCLES after BM_WAIT entry.
      b_ch = c_ch;
      send_frame(64, 63);
      tick();
      tick();
      seen = 1'b0;
      for (int k = 0; k < 1023; k++) begin
         if (frame_err) seen = 1'b1;
         tick();
      end
      chk("tmo_no_early_err", seen, 1'b0);
      tick();
      chk("tmo_frame_err", frame_err, 1'b1);
      chk("tmo_idle", busy, 1'b0);
      chk("tmo_no_chien", c_ch - b_ch, 0);

      // bm_done on the timeout cycle wins.
      send_frame(64, 63);
      tick();
      tick();
      repeat (1023) tick();
      bm_done = 1'b1;
      tick();
      bm_done = 1'b0;
      chk("tmo_race_no_err", frame_err, 1'b0);
      chk("tmo_race_chien_start", chien_start, 1'b1);
      tick();
      chien_done = 1'b1;
      tick();
      chien_done = 1'b0;
      chk("tmo_race_frame_done", frame_done, 1'b1);
      tick();

      // Reset while in CH_WAIT, late chien_done ignored.
      send_frame(64, 63);
      tick(); tick(); tick(); tick();
      bm_done = 1'b1;
      tick();
      bm_done = 1'b0;
      tick();
      chk("chwait_busy", busy, 1'b1);
      b_fd = c_fd; b_fe = c_fe;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_mid_busy", busy, 1'b0);
      chk("rst_mid_s_ready", s_ready, 1'b1);
      tick();
      chien_done = 1'b1;
      tick();
      chien_done = 1'b0;
      tick();
      chk("rst_mid_no_done", c_fd - b_fd, 0);
      chk("rst_mid_no_err", c_fe - b_fe, 0);
      chk("rst_mid_still_idle", busy, 1'b0);

      // Spurious bm_done while idle.
      bm_done = 1'b1;
      tick();
      bm_done = 1'b0;
      chk("spurious_bm_idle", busy, 1'b0);
      chk("spurious_no_chien", chien_start, 1'b0);

      // Zero-syndrome frame.
      b_bm = c_bm;
      synd_zero = 1'b1;
      send_frame(64, 63);
`ifdef RS_ZERO_SYND_SKIP_EN
      tick();
      chk("skip_frame_done", frame_done, 1'b1);
      chk("skip_no_bm", c_bm - b_bm, 0);
      synd_zero = 1'b0;
      tick();
      chk("skip_idle", busy, 1'b0);
`else
      synd_zero = 1'b0;
      finish_nominal();
      chk("noskip_bm_count", c_bm - b_bm, 1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
